// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: datapath width, ALUOp codes
// and the packed entry format held in the result FIFO.
package alu_pkg;

    localparam int ALU_WIDTH = 6;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        logic                 carry;
        logic                 zero;
        logic                 negative;
        logic                 overflow;
    } alu_entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational condition-flag derivation for one ALU result.
// Carry and overflow are only meaningful for ADD/SUB; every other op reports 0.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] result,
    input  logic             cout,
    input  logic [3:0]       op,
    input  logic             a_msb,
    input  logic             b_msb,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    logic res_msb;
    assign res_msb = result[WIDTH-1];

    always_comb begin
        carry    = 1'b0;
        overflow = 1'b0;
        zero     = (result == '0);
        negative = res_msb;
        case (op)
            OP_ADD: begin
                carry    = cout;
                overflow = (a_msb == b_msb) && (res_msb != a_msb);
            end
            // a - b flips the effective sign of b, hence the inverted MSB test
            OP_SUB: begin
                carry    = cout;
                overflow = (a_msb != b_msb) && (res_msb != a_msb);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// Captures ALU results with derived flags into a 2-entry FIFO toward writeback.
// Optional sticky carry/overflow accumulation is enabled by ALU_STICKY_FLAGS_EN.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry_out,
    input  logic [3:0]       alu_op,
    input  logic             a_msb,
    input  logic             b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_negative,
    output logic             out_overflow,
`ifdef ALU_STICKY_FLAGS_EN
    input  logic             sticky_clr,
    output logic             sticky_carry,
    output logic             sticky_overflow,
`endif
    output logic [1:0]       count
);

    alu_entry_t mem_reg [0:1];
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;

    alu_entry_t new_entry;
    alu_entry_t head;
    logic       push;
    logic       pop;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .result   (alu_result),
        .cout     (alu_carry_out),
        .op       (alu_op),
        .a_msb    (a_msb),
        .b_msb    (b_msb),
        .carry    (new_entry.carry),
        .zero     (new_entry.zero),
        .negative (new_entry.negative),
        .overflow (new_entry.overflow)
    );
    assign new_entry.result = alu_result;

    // Ready depends only on occupancy, so there is no path from out_ready.
    assign in_ready  = (count_reg != 2'(DEPTH));
    assign out_valid = (count_reg != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: stale slots are never visible while count is 0.
    always_ff @(posedge clk) begin
        if (push) mem_reg[wr_ptr_reg] <= new_entry;
    end

    assign head         = mem_reg[rd_ptr_reg];
    assign out_result   = out_valid ? head.result   : '0;
    assign out_carry    = out_valid ? head.carry    : 1'b0;
    assign out_zero     = out_valid ? head.zero     : 1'b0;
    assign out_negative = out_valid ? head.negative : 1'b0;
    assign out_overflow = out_valid ? head.overflow : 1'b0;

`ifdef ALU_STICKY_FLAGS_EN
    logic sticky_carry_reg;
    logic sticky_overflow_reg;

    // A clear in the same cycle as a pop discards that pop's flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_carry_reg    <= 1'b0;
            sticky_overflow_reg <= 1'b0;
        end else if (sticky_clr) begin
            sticky_carry_reg    <= 1'b0;
            sticky_overflow_reg <= 1'b0;
        end else if (pop) begin
            sticky_carry_reg    <= sticky_carry_reg    | head.carry;
            sticky_overflow_reg <= sticky_overflow_reg | head.overflow;
        end
    end

    assign sticky_carry    = sticky_carry_reg;
    assign sticky_overflow = sticky_overflow_reg;
`endif

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream consumer of the 6-bit ripple ALU. Captures its combinational Result/CarryOut each cycle the producer marks valid.
- Derives condition flags: zero, negative, signed overflow, carry.
- Buffers results in a 2-entry FIFO with valid/ready handshake toward writeback, so the ALU can issue back-to-back without a combinational ready path.

Parameters:
- WIDTH, 6, datapath width; must match ALU width.
- DEPTH, 2, FIFO entries. Fixed at 2; other values are unsupported.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  ALU result and side info valid this cycle
- in_ready  output  1  stage can accept an entry this cycle
- alu_result  input  WIDTH  ALU Result bus
- alu_carry_out  input  1  ALU CarryOut of MSB slice
- alu_op  input  4  ALUOp used for this result
- a_msb  input  1  operand a[WIDTH-1]
- b_msb  input  1  operand b[WIDTH-1]
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer takes head this cycle
- out_result  output  WIDTH  head result
- out_carry  output  1  head carry flag
- out_zero  output  1  head zero flag
- out_negative  output  1  head negative flag
- out_overflow  output  1  head signed-overflow flag
- count  output  2  current occupancy, 0..2

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-high, named reset.
- ALUOp encoding:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 1100 NOR
  - any other code is treated as logical.
- Flag rules, computed at push time:
  - zero = (alu_result == 0).
  - negative = alu_result[WIDTH-1].
  - carry = alu_carry_out for ADD/SUB, otherwise 0.
  - overflow for ADD = (a_msb == b_msb) && (res_msb != a_msb).
  - overflow for SUB = (a_msb != b_msb) && (res_msb != a_msb).
  - overflow for all other ops = 0.
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- in_ready = (count != 2). This is a function of registered state only, with no combinational path from out_ready.
- out_valid = (count != 0).
- Latency: an entry pushed at edge N is visible at the outputs from edge N onward (out_valid high in cycle N+1) when the FIFO was empty.
- Ordering is strict FIFO. The head is presented on out_* and held stable while out_valid && !out_ready.
- Simultaneous push and pop at count 1: count stays 1, the old head leaves, and the new entry becomes head.
- Simultaneous push and pop at count 0: cannot occur, since out_valid is 0.
- Full (count 2): in_ready is 0, so no push occurs; a pop drops count to 1 and in_ready rises the next cycle.
- Empty: out_result, out_carry, out_zero, out_negative and out_overflow all read 0.
- Pointers are 1-bit read/write indices that wrap modulo 2.
- Reset, including mid-transfer: count = 0, pointers = 0, out_valid = 0, in_ready = 1 after reset deasserts, and all data/flag outputs = 0. Buffered entries are discarded.

Optional Feature:
- Macro: ALU_STICKY_FLAGS_EN.
- When defined:
  - Adds input sticky_clr (1) and outputs sticky_carry (1) and sticky_overflow (1).
  - Each sticky bit ORs in the corresponding flag of every popped entry.
  - sticky_clr clears both bits synchronously. If a pop coincides with sticky_clr, the clear wins and that pop's flags are lost.
  - reset clears both bits.
- When undefined: the ports and registers are absent, and all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_WIDTH = 6.
  - ALUOp constants OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR.
  - A packed struct alu_entry_t {result, carry, zero, negative, overflow}.
- One sub-module, alu_flag_gen: combinational flag derivation from result, carry, op and the operand MSBs.
- The FIFO storage stays inline in alu_result_stage.

Test Plan:
- Reset mid-transfer: push 2 entries, assert reset for 1 cycle -> count = 0, out_valid = 0, out_result = 0, in_ready = 1 after release.
- ADD overflow: alu_op = 0010, a_msb = 0, b_msb = 0, alu_result = 6'b100000, carry_out = 0 -> out_overflow = 1, out_negative = 1, out_zero = 0, out_carry = 0.
- SUB equal operands: alu_op = 0110, a_msb = 1, b_msb = 1, alu_result = 0, carry_out = 1 -> out_zero = 1, out_carry = 1, out_overflow = 0.
- Logical op masking: alu_op = 0000, alu_result = 6'h15, carry_out = 1 -> out_carry = 0, out_overflow = 0, out_result = 6'h15.
- Backpressure: out_ready = 0, push 3 back-to-back -> first two accepted, in_ready = 0 on the third, count = 2. Then raise out_ready -> values pop in order with no loss or duplication.
- Concurrent push/pop at count 1: push 6'h01, then on the next edge push 6'h02 while out_ready = 1 -> count stays 1, out_result = 6'h02. With ALU_STICKY_FLAGS_EN, pop an overflowing entry -> sticky_overflow = 1 until sticky_clr.
